// File: rtl/reset_seq_pkg.sv
// Shared types for the reset-source sequencer: FSM state encoding and select values.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop reset-deassertion synchroniser: asynchronous clear, synchronous flush,
// output rises on the second CLK edge after clr_n is released.
module reset_sync_2ff (
  input  logic CLK,
  input  logic clr_n,
  input  logic flush,
  output logic sync_n
);

  logic [1:0] ff;

  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      ff <= 2'b00;
    end else if (flush) begin
      ff <= 2'b00;
    end else begin
      ff <= {ff[0], 1'b1};
    end
  end

  assign sync_n = ff[1];

endmodule

// File: rtl/reset_source_sequencer.sv
// Glitch-free switch of the output reset between source A and source B.
// Optional RELEASE timeout with sticky ERR is enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_source_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  input  logic A_RST_N,
  input  logic B_RST_N,
  output logic SEL,
  output logic RST_N_OUT,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q;
  logic             req_sel_q;
  logic             gate_q;
  logic             accept;
  logic             flush;
  logic             done_c;
  logic             err_set;
  logic             src_n;
  logic             sync_n;

  assign accept = REQ_VALID && (state_q == IDLE);
  assign src_n  = (sel_q == SEL_A) ? A_RST_N : B_RST_N;

  // Source assertion clears the synchroniser asynchronously; release is re-timed to CLK.
  reset_sync_2ff u_sync (
    .CLK    (CLK),
    .clr_n  (RST_N & src_n),
    .flush  (flush),
    .sync_n (sync_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    done_c  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == HOLD_LAST) state_d = SWITCH;
      end
      SWITCH: begin
        flush   = 1'b1;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        // Synchroniser held empty so release timing starts fresh on RELEASE entry.
        flush = 1'b1;
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == SETTLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (sync_n) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
          cnt_d = sat_inc(cnt_q);
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_set = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_B;
      gate_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= (state_d == IDLE) || (state_d == RELEASE);
      if (state_q == SWITCH) sel_q <= req_sel_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) req_sel_q <= REQ_SEL;
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_err_set;
  assign unused_err_set = err_set;
  assign ERR = 1'b0;
`endif

  // Output gate is registered so a state change cannot glitch RST_N_OUT high.
  assign RST_N_OUT = gate_q & sync_n & src_n;
  assign DONE      = done_c;
  assign SEL       = sel_q;
  assign REQ_READY = (state_q == IDLE);
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_reset_source_sequencer.sv
// Directed bench for reset_source_sequencer (HOLD=4, SETTLE=8); timeout case runs
// only when RESET_SEQ_TIMEOUT_EN is defined.
module tb_reset_source_sequencer;

  logic CLK = 1'b0;
  logic RST_N, REQ_VALID, REQ_SEL, A_RST_N, B_RST_N;
  logic REQ_READY, SEL, RST_N_OUT, BUSY, DONE, ERR;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  reset_source_sequencer #(
    .HOLD_CYCLES    (4),
    .SETTLE_CYCLES  (8),
    .CNT_W          (8),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_SEL   (REQ_SEL),
    .REQ_READY (REQ_READY),
    .A_RST_N   (A_RST_N),
    .B_RST_N   (B_RST_N),
    .SEL       (SEL),
    .RST_N_OUT (RST_N_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic request(input logic sel);
    REQ_VALID = 1'b1;
    REQ_SEL   = sel;
    tick();
    REQ_VALID = 1'b0;
  endtask

  initial begin
    logic flag;
    logic done_seen;
    int   err_edge;

    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_SEL = 1'b0;
    A_RST_N = 1'b1; B_RST_N = 1'b1;

    // Power-up reset
    repeat (3) tick();
    check("rst_out_in_reset", RST_N_OUT, 0);
    check("sel_in_reset", SEL, 0);
    check("busy_in_reset", BUSY, 0);
    check("done_in_reset", DONE, 0);
    check("err_in_reset", ERR, 0);
    check("ready_in_reset", REQ_READY, 1);
    RST_N = 1'b1;
    tick();
    check("rst_out_edge1", RST_N_OUT, 0);
    tick();
    check("rst_out_edge2", RST_N_OUT, 1);

    // Switch B -> A with source A idle-high
    request(1'b1);
    check("busy_after_accept", BUSY, 1);
    check("ready_after_accept", REQ_READY, 0);
    check("rst_out_assert", RST_N_OUT, 0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 4)  check("sel_edge4", SEL, 0);
      if (e == 5)  check("sel_edge5", SEL, 1);
      if (e == 10) check("rst_out_settle", RST_N_OUT, 0);
      if (e == 14) check("done_edge14", DONE, 0);
      if (e == 14) check("rst_out_edge14", RST_N_OUT, 0);
      if (e == 15) check("done_edge15", DONE, 1);
      if (e == 15) check("rst_out_edge15", RST_N_OUT, 1);
      if (e == 16) check("done_edge16", DONE, 0);
      if (e == 16) check("busy_edge16", BUSY, 0);
      if (e == 16) check("rst_out_edge16", RST_N_OUT, 1);
    end

    // Same-source request; A reasserts during SETTLE and releases 20 cycles later
    request(1'b1);
    repeat (7) tick();
    A_RST_N = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      flag = flag | RST_N_OUT | DONE;
    end
    check("held_while_src_low", flag, 0);
    check("busy_while_src_low", BUSY, 1);
    A_RST_N = 1'b1;
    tick();
    check("done_1_after_rise", DONE, 0);
    tick();
    check("done_2_after_rise", DONE, 1);
    check("rst_out_2_after_rise", RST_N_OUT, 1);
    check("sel_same_src", SEL, 1);
    tick();
    check("idle_after_src_seq", BUSY, 0);

    // RST_N pulsed during ASSERT aborts immediately
    request(1'b1);
    repeat (2) tick();
    RST_N = 1'b0;
    #1;
    check("abort_busy", BUSY, 0);
    check("abort_sel", SEL, 0);
    check("abort_rst_out", RST_N_OUT, 0);
    check("abort_ready", REQ_READY, 1);
    tick();
    RST_N = 1'b1;
    repeat (2) tick();
    check("rst_out_after_abort", RST_N_OUT, 1);

    // Requests while busy are ignored
    request(1'b1);
    REQ_VALID = 1'b1;
    REQ_SEL   = 1'b0;
    tick();
    check("ready_while_busy", REQ_READY, 0);
    repeat (7) tick();
    REQ_VALID = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE) begin
        done_seen = 1'b1;
        break;
      end
    end
    check("done_seen_ignore", done_seen, 1);
    check("sel_first_request", SEL, 1);
    tick();
    check("busy_after_ignore", BUSY, 0);
    check("rst_out_after_ignore", RST_N_OUT, 1);

`ifdef RESET_SEQ_TIMEOUT_EN
    // Timeout while source A is held in reset
    A_RST_N = 1'b0;
    request(1'b1);
    done_seen = 1'b0;
    err_edge  = 0;
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (DONE) done_seen = 1'b1;
      if (ERR) begin
        err_edge = e;
        break;
      end
    end
    check("timeout_edge", err_edge, 268);
    check("timeout_no_done", done_seen, 0);
    check("timeout_ready", REQ_READY, 1);
    check("timeout_busy", BUSY, 0);
    check("timeout_rst_out", RST_N_OUT, 0);
    A_RST_N = 1'b1;
    repeat (2) tick();
    check("err_sticky", ERR, 1);
    check("rst_out_after_err", RST_N_OUT, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
